// File: rtl/gray_sweep_ctrl.sv
// Sweep sequencer for a bin-to-Gray / Gray-to-bin converter pair.
// Walks every code, checks round trip and single-bit Gray steps.
module gray_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] bin_out,
  input  logic [W-1:0] gray_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W:0]   err_cnt,
  output logic         rt_err,
  output logic         adj_err,
  output logic [W-1:0] first_err_code,
  output logic         first_err_vld
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [W:0]    ERR_ONE  = (W+1)'(1);
  localparam logic [W-1:0]  BIN_ONE  = W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_bin;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_prev_gray;
  logic [W-1:0]  r_gray0;
  logic [W:0]    r_err_cnt;
  logic          r_rt_err;
  logic          r_adj_err;
  logic [W-1:0]  r_first_code;
  logic          r_first_vld;

  logic          w_last;
  logic [W-1:0]  w_d_prev;
  logic [W-1:0]  w_d_wrap;
  logic          w_one_prev;
  logic          w_one_wrap;
  logic          w_rt_fail;
  logic          w_adj_fail;
  logic          w_any_fail;

  assign w_last   = &r_bin;
  assign w_d_prev = gray_in ^ r_prev_gray;
  assign w_d_wrap = gray_in ^ r_gray0;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
  assign w_one_prev = (|w_d_prev) &&
                      ~|(w_d_prev & (w_d_prev - BIN_ONE));
  assign w_one_wrap = (|w_d_wrap) &&
                      ~|(w_d_wrap & (w_d_wrap - BIN_ONE));

  assign w_rt_fail  = (b_in != r_bin);
  assign w_adj_fail = ((r_bin != '0) && !w_one_prev) ||
                      (w_last && !w_one_wrap);
  assign w_any_fail = w_rt_fail || w_adj_fail;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy        = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bin        <= '0;
      r_cnt        <= '0;
      r_prev_gray  <= '0;
      r_gray0      <= '0;
      r_err_cnt    <= '0;
      r_rt_err     <= 1'b0;
      r_adj_err    <= 1'b0;
      r_first_code <= '0;
      r_first_vld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin        <= '0;
            r_cnt        <= '0;
            r_err_cnt    <= '0;
            r_rt_err     <= 1'b0;
            r_adj_err    <= 1'b0;
            r_first_code <= '0;
            r_first_vld  <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + CW'(1);
        end
        S_CHECK: begin
          if (r_bin == '0) r_gray0 <= gray_in;
          r_prev_gray <= gray_in;
          if (w_any_fail) begin
            r_err_cnt <= r_err_cnt + ERR_ONE;
            if (w_rt_fail)  r_rt_err  <= 1'b1;
            if (w_adj_fail) r_adj_err <= 1'b1;
            if (!r_first_vld) begin
              r_first_code <= r_bin;
              r_first_vld  <= 1'b1;
            end
          end
          // Final code holds bin_out so the last value stays visible.
          if (!w_last) begin
            r_bin <= r_bin + BIN_ONE;
            r_cnt <= '0;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bin_out        = r_bin;
  assign err_cnt        = r_err_cnt;
  assign rt_err         = r_rt_err;
  assign adj_err        = r_adj_err;
  assign first_err_code = r_first_code;
  assign first_err_vld  = r_first_vld;

endmodule
